// File: rtl/rq_to_r3_reduce.sv
// Rq -> R3 reduction stage: streams P coefficients out of Rq memory, centres
// each one, reduces it mod 3 to a ternary value and writes it to R3 memory.
module rq_to_r3_reduce #(
  parameter int P  = 757,
  parameter int Q  = 7879,
  parameter int W  = 242,
  parameter int AW = 11
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic [AW-1:0] mem_address_o,
  output logic          mem_rd_en,
  input  logic [12:0]   mem_output,
  output logic [AW-1:0] r3_wr_addr,
  output logic [1:0]    r3_wr_data,
  output logic          r3_wr_en,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] weight,
  output logic          weight_ok,
  output logic          range_err
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  localparam logic [AW-1:0] LAST = AW'(P - 1);
  localparam logic [13:0]   HALF = 14'((Q - 1) / 2);
  localparam logic [13:0]   QV   = 14'(Q);

  state_t        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          drain_q, drain_d;
  logic [AW-1:0] weight_q, weight_d;
  logic          wok_q, wok_d;
  logic          rerr_q, rerr_d;

  logic          v1_q;
  logic [AW-1:0] a1_q;
  logic          wen_q;
  logic [AW-1:0] waddr_q;
  logic [1:0]    wdata_q;

  // Residue of v mod 3: base-4 digits are each congruent to themselves mod 3.
  function automatic logic [1:0] mod3(input logic [13:0] v);
    logic [4:0] s;
    logic [3:0] t;
    logic [2:0] u;
    s = '0;
    for (int unsigned k = 0; k < 7; k++) s = s + 5'(v[2*k +: 2]);
    t = 4'(s[1:0]) + 4'(s[3:2]) + 4'(s[4]);
    u = 3'(t[1:0]) + 3'(t[3:2]);
    case (u)
      3'd3:    mod3 = 2'd0;
      3'd4:    mod3 = 2'd1;
      default: mod3 = u[1:0];
    endcase
  endfunction

  // Centring splits into a magnitude plus a sign so only an unsigned reduction is needed.
  logic [13:0] x14, mag;
  logic        neg;
  logic [1:0]  res;
  logic [1:0]  r_enc;
  logic        in_range_err;

  always_comb begin
    x14 = {1'b0, mem_output};
    mag = x14;
    neg = 1'b0;
    if (x14 > HALF) begin
      if (x14 >= QV) begin
        mag = x14 - QV;
      end else begin
        mag = QV - x14;
        neg = 1'b1;
      end
    end
    res = mod3(mag);
    case ({neg, res})
      3'b001:  r_enc = 2'b01;
      3'b010:  r_enc = 2'b11;
      3'b101:  r_enc = 2'b11;
      3'b110:  r_enc = 2'b01;
      default: r_enc = 2'b00;
    endcase
    in_range_err = (x14 >= QV);
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    drain_d  = drain_q;
    weight_d = weight_q;
    wok_d    = wok_q;
    rerr_d   = rerr_q;
    if (v1_q) begin
      if (res != 2'd0 && weight_q != '1) weight_d = weight_q + 1'b1;
      if (in_range_err) rerr_d = 1'b1;
    end
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_READ;
          idx_d    = '0;
          weight_d = '0;
          wok_d    = 1'b0;
          rerr_d   = 1'b0;
        end
      end
      S_READ: begin
        if (idx_q == LAST) begin
          state_d = S_DRAIN;
          drain_d = 1'b0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (drain_q) begin
          state_d = S_DONE;
          wok_d   = (weight_q == AW'(W));
        end else begin
          drain_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      drain_q  <= 1'b0;
      weight_q <= '0;
      wok_q    <= 1'b0;
      rerr_q   <= 1'b0;
      v1_q     <= 1'b0;
      a1_q     <= '0;
      wen_q    <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      drain_q  <= drain_d;
      weight_q <= weight_d;
      wok_q    <= wok_d;
      rerr_q   <= rerr_d;
      v1_q     <= (state_q == S_READ);
      a1_q     <= idx_q;
      wen_q    <= v1_q;
      if (v1_q) begin
        waddr_q <= a1_q;
        wdata_q <= r_enc;
      end
    end
  end

  assign mem_rd_en     = (state_q == S_READ);
  assign mem_address_o = idx_q;
  assign busy          = (state_q == S_READ) || (state_q == S_DRAIN);
  assign done          = (state_q == S_DONE);
  assign r3_wr_en      = wen_q;
  assign r3_wr_addr    = waddr_q;
  assign r3_wr_data    = wdata_q;
  assign weight        = weight_q;
  assign weight_ok     = wok_q;
  assign range_err     = rerr_q;

endmodule
